// File: rtl/regfile_mux_nrd.sv
// Register file with NUM_RD independent registered read ports, write bypass,
// an optional hardwired-zero r0, and zero-valued out-of-range selects.

module regfile_mux_nrd_port #(
    parameter int REG_SIZE = 32,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [SEL_W-1:0]                   sel,
    input  logic [NUM_REGS-1:0][REG_SIZE-1:0]  regs,
    input  logic                               wr_en,
    input  logic [SEL_W-1:0]                   wr_sel,
    input  logic [REG_SIZE-1:0]                wr_data,
    output logic [REG_SIZE-1:0]                data,
    output logic                               valid
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

    logic                in_range;
    logic                is_zero;
    logic [REG_SIZE-1:0] value;

    assign in_range = ({1'b0, sel} < NREGS);
    assign is_zero  = (ZERO_REG != 0) && (sel == '0);

    // Priority: out-of-range, hardwired zero, bypass, stored value.
    always_comb begin
        value = '0;
        if (in_range && !is_zero) begin
            if ((BYPASS != 0) && wr_en && (wr_sel == sel))
                value = wr_data;
            else
                value = regs[sel[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en)
                data <= value;
        end
    end
endmodule

module regfile_mux_nrd #(
    parameter int REG_SIZE = 32,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [SEL_W-1:0]             wr_sel,
    input  logic [REG_SIZE-1:0]          wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*SEL_W-1:0]      rd_sel,
    output logic [NUM_RD*REG_SIZE-1:0]   rd_data,
    output logic [NUM_RD-1:0]            rd_valid
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][REG_SIZE-1:0] regs;
    logic                              wr_ok;

    // Out-of-range and r0 (when hardwired) writes are dropped here.
    assign wr_ok = wr_en && ({1'b0, wr_sel} < NREGS) &&
                   !((ZERO_REG != 0) && (wr_sel == '0));

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (wr_ok)
            regs[wr_sel[IDX_W-1:0]] <= wr_data;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_mux_nrd_port #(
            .REG_SIZE (REG_SIZE),
            .NUM_REGS (NUM_REGS),
            .SEL_W    (SEL_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .en      (rd_en[p]),
            .sel     (rd_sel[p*SEL_W +: SEL_W]),
            .regs    (regs),
            .wr_en   (wr_en),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
            .data    (rd_data[p*REG_SIZE +: REG_SIZE]),
            .valid   (rd_valid[p])
        );
    end
endmodule

// File: tb/tb_regfile_mux_nrd.sv
// Directed bench: three configurations share one stimulus stream
// (a: defaults, b: no bypass / no zero reg, c: 24 registers).

module tb_regfile_mux_nrd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_sel = '0;
    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]  rd_valid_a, rd_valid_b, rd_valid_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mux_nrd #(.ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

    regfile_mux_nrd #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

    regfile_mux_nrd #(.NUM_REGS(24)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_c), .rd_valid(rd_valid_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic en, input int s, input logic [31:0] d);
        wr_en = en;
        wr_sel = 5'(s);
        wr_data = d;
    endtask

    task automatic rd(input logic [1:0] en, input int s0, input int s1);
        rd_en = en;
        rd_sel = {5'(s1), 5'(s0)};
    endtask

    initial begin
        // Reset held two cycles
        wr(1'b1, 4, 32'h0BADF00D);
        rd(2'b11, 4, 4);
        tick();
        tick();
        chk("rst_valid_a", 32'(rd_valid_a), 32'h0);
        chk("rst_data_a0", rd_data_a[31:0], 32'h0);
        chk("rst_data_a1", rd_data_a[63:32], 32'h0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'h0);
        chk("rst_valid_c", 32'(rd_valid_c), 32'h0);
        rst = 1'b0;
        wr(1'b0, 0, 32'h0);

        // Every index reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rd(2'b11, i, 31 - i);
            tick();
            chk($sformatf("zero_a0_r%0d", i), rd_data_a[31:0], 32'h0);
            chk($sformatf("zero_a1_r%0d", 31 - i), rd_data_a[63:32], 32'h0);
            chk($sformatf("zero_c0_r%0d", i), rd_data_c[31:0], 32'h0);
            chk($sformatf("zero_vld_a_%0d", i), 32'(rd_valid_a), 32'h3);
        end

        // Write r5, read it back on both ports
        wr(1'b1, 5, 32'hDEADBEEF);
        rd(2'b00, 0, 0);
        tick();
        chk("wr_noread_vld_a", 32'(rd_valid_a), 32'h0);
        wr(1'b0, 0, 32'h0);
        rd(2'b11, 5, 5);
        tick();
        chk("r5_a0", rd_data_a[31:0], 32'hDEADBEEF);
        chk("r5_a1", rd_data_a[63:32], 32'hDEADBEEF);
        chk("r5_b0", rd_data_b[31:0], 32'hDEADBEEF);
        chk("r5_c1", rd_data_c[63:32], 32'hDEADBEEF);
        chk("r5_vld_a", 32'(rd_valid_a), 32'h3);

        // Bypass vs. old value
        wr(1'b1, 7, 32'h11111111);
        rd(2'b00, 0, 0);
        tick();
        wr(1'b1, 7, 32'h22222222);
        rd(2'b11, 7, 7);
        tick();
        chk("byp_a0", rd_data_a[31:0], 32'h22222222);
        chk("byp_a1", rd_data_a[63:32], 32'h22222222);
        chk("nobyp_b0", rd_data_b[31:0], 32'h11111111);
        chk("nobyp_b1", rd_data_b[63:32], 32'h11111111);
        chk("byp_c0", rd_data_c[31:0], 32'h22222222);
        wr(1'b0, 0, 32'h0);
        tick();
        chk("nobyp_next_b0", rd_data_b[31:0], 32'h22222222);

        // Zero register, stored and bypassed
        wr(1'b1, 0, 32'hFFFFFFFF);
        rd(2'b00, 0, 0);
        tick();
        wr(1'b0, 0, 32'h0);
        rd(2'b11, 0, 5);
        tick();
        chk("r0_a0", rd_data_a[31:0], 32'h0);
        chk("r0_b0", rd_data_b[31:0], 32'hFFFFFFFF);
        chk("r0_c0", rd_data_c[31:0], 32'h0);
        chk("mixed_a1_r5", rd_data_a[63:32], 32'hDEADBEEF);
        wr(1'b1, 0, 32'hFFFFFFFF);
        rd(2'b11, 0, 0);
        tick();
        chk("r0_byp_a0", rd_data_a[31:0], 32'h0);
        chk("r0_byp_c1", rd_data_c[63:32], 32'h0);
        chk("r0_byp_b0", rd_data_b[31:0], 32'hFFFFFFFF);

        // Out-of-range index on the 24-register instance
        wr(1'b1, 3, 32'hA5A5A5A5);
        rd(2'b00, 0, 0);
        tick();
        wr(1'b1, 30, 32'h12345678);
        tick();
        wr(1'b1, 30, 32'h55555555);
        rd(2'b11, 30, 6);
        tick();
        chk("oor_c0", rd_data_c[31:0], 32'h0);
        chk("oor_alias_c1", rd_data_c[63:32], 32'h0);
        chk("r30_byp_a0", rd_data_a[31:0], 32'h55555555);
        chk("r30_old_b0", rd_data_b[31:0], 32'h12345678);
        wr(1'b0, 0, 32'h0);
        rd(2'b11, 30, 3);
        tick();
        chk("oor_rd_c0", rd_data_c[31:0], 32'h0);
        chk("r3_c1", rd_data_c[63:32], 32'hA5A5A5A5);

        // Hold: rd_en dropped while r3 is overwritten
        rd(2'b01, 3, 0);
        tick();
        chk("hold_pre_a0", rd_data_a[31:0], 32'hA5A5A5A5);
        chk("hold_pre_vld_a", 32'(rd_valid_a), 32'h1);
        wr(1'b1, 3, 32'h0);
        rd(2'b00, 3, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_a0_%0d", k), rd_data_a[31:0], 32'hA5A5A5A5);
            chk($sformatf("hold_c0_%0d", k), rd_data_c[31:0], 32'hA5A5A5A5);
            chk($sformatf("hold_vld_a_%0d", k), 32'(rd_valid_a), 32'h0);
        end
        wr(1'b0, 0, 32'h0);
        rd(2'b01, 3, 0);
        tick();
        chk("r3_cleared_a0", rd_data_a[31:0], 32'h0);

        // Reset mid-run discards a pending write and read
        wr(1'b1, 9, 32'h99999999);
        rd(2'b00, 0, 0);
        tick();
        rd(2'b11, 9, 9);
        tick();
        chk("r9_pre_a0", rd_data_a[31:0], 32'h99999999);
        rst = 1'b1;
        wr(1'b1, 9, 32'h77777777);
        rd(2'b11, 9, 9);
        tick();
        chk("midrst_a0", rd_data_a[31:0], 32'h0);
        chk("midrst_a1", rd_data_a[63:32], 32'h0);
        chk("midrst_vld_a", 32'(rd_valid_a), 32'h0);
        rst = 1'b0;
        wr(1'b0, 0, 32'h0);
        rd(2'b11, 9, 5);
        tick();
        chk("post_rst_r9_a0", rd_data_a[31:0], 32'h0);
        chk("post_rst_r5_a1", rd_data_a[63:32], 32'h0);
        chk("post_rst_r9_b0", rd_data_b[31:0], 32'h0);
        chk("post_rst_vld_a", 32'(rd_valid_a), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
